// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, runs the single-outstanding imem
// handshake and buffers fetched words in a small FWFT FIFO toward decode.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RST     | first cycle after reset, no request yet
//   REQ     | imem_req_o high at the fetch PC, waiting for grant
//   WAIT    | request granted, waiting for its response
//   DISCARD | granted response belongs to a flushed path, drop it on arrival
//   HOLD    | buffer full, no request until decode pops
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    input  logic        id_ready_i
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        ST_RST,
        ST_REQ,
        ST_WAIT,
        ST_DISCARD,
        ST_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          req_q, req_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   pc_mem_d    [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   redirect_pc;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_nxt;
    logic          unused_redirect_lsb;

    assign redirect_pc         = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Redirect wins over both the same-cycle push and pop; the FIFO is simply cleared.
    assign push      = (state_q == ST_WAIT) && imem_rvalid_i && !redirect_i;
    assign pop       = (count_q != '0) && id_ready_i && !redirect_i;
    assign count_nxt = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_RST: begin
                state_d = ST_REQ;
                if (redirect_i) pc_d = redirect_pc;
            end
            ST_REQ: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc;
                    state_d = imem_gnt_i ? ST_DISCARD : ST_REQ;
                end else if (imem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc;
                    state_d = imem_rvalid_i ? ST_REQ : ST_DISCARD;
                end else if (imem_rvalid_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = (count_nxt < CW'(DEPTH)) ? ST_REQ : ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (redirect_i) pc_d = redirect_pc;
                if (imem_rvalid_i) state_d = ST_REQ;
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc;
                    state_d = ST_REQ;
                end else if (pop) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_RST;
        endcase
        req_d = (state_d == ST_REQ);
    end

    always_comb begin
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (redirect_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = imem_rdata_i;
                pc_mem_d[wr_ptr_q]    = pc_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            instr_mem_q <= '{default: '0};
            pc_mem_q    <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign if_valid_o  = (count_q != '0);
    assign if_instr_o  = instr_mem_q[rd_ptr_q];
    assign if_pc_o     = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed handshake/redirect/reset scenarios plus a random run,
// checked against a transaction-level model of the fetch stream and buffer occupancy.
module tb_fetch_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        id_ready_i = 1'b0;

    logic        rst2_n = 1'b0;
    logic        req2;
    logic [31:0] addr2;
    logic        gnt2 = 1'b0;
    logic        rvalid2 = 1'b0;
    logic [31:0] rdata2 = '0;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
        .id_ready_i(id_ready_i)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst2_n), .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt2),
        .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
        .if_valid_o(valid2), .if_instr_o(instr2), .if_pc_o(pc2),
        .id_ready_i(1'b1)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] issue_exp;
    logic [31:0] deliver_exp;
    int          occ_m;
    bit          rsp_pend;
    int          rsp_cnt;
    logic [31:0] rsp_addr;
    bit          rsp_stale;
    bit          redir_prev;
    int          pops;

    logic [31:0] addrs2[$];
    logic [31:0] pcs2[$];
    logic [31:0] instrs2[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) r = {28'hFFF_FFFF, r[3:0]};
        return r;
    endfunction

    task automatic do_reset(input bit late);
        @(negedge clk);
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        id_ready_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        #1;
        chk("rst_req",   imem_req_o,  32'h0);
        chk("rst_addr",  imem_addr_o, 32'h0);
        chk("rst_valid", if_valid_o,  32'h0);
        chk("rst_instr", if_instr_o,  32'h0);
        chk("rst_pc",    if_pc_o,     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // a response left over from before reset shows up while the DUT sits in RST
        if (late && rsp_pend) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end
        rsp_pend    = 1'b0;
        rsp_stale   = 1'b0;
        issue_exp   = 32'h0;
        deliver_exp = 32'h0;
        occ_m       = 0;
        redir_prev  = 1'b0;
    endtask

    // One cycle: observe at negedge, then drive memory/decode/redirect for the next edge.
    // dly >= 0: grant every request, response dly cycles after the grant cycle + 1.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt, input int dly);
        bit busy;
        bit fire;
        bit fire_good;
        bit gnt;
        bit pop_m;
        @(negedge clk);
        busy = rsp_pend;
        chk("if_valid", if_valid_o, 32'(occ_m != 0));
        chk("imem_req", imem_req_o, 32'(!busy && occ_m < int'(DEPTH)));
        if (imem_req_o) chk("imem_addr", imem_addr_o, issue_exp);
        if (redir_prev) chk("valid_after_redirect", if_valid_o, 32'h0);

        fire = 1'b0;
        if (rsp_pend) begin
            if (rsp_cnt == 0) begin
                fire     = 1'b1;
                rsp_pend = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
        imem_rvalid_i = fire;
        imem_rdata_i  = fire ? (rsp_addr ^ KEY) : $urandom;
        fire_good     = fire && !rsp_stale && !redir;

        gnt = imem_req_o && (dly >= 0 || $urandom_range(0, 2) != 0);
        imem_gnt_i = gnt;
        if (gnt) begin
            rsp_pend  = 1'b1;
            rsp_cnt   = (dly >= 0) ? dly : int'($urandom_range(0, 3));
            rsp_addr  = imem_addr_o;
            rsp_stale = redir;
            issue_exp = issue_exp + 32'd4;
        end else if (redir) begin
            rsp_stale = 1'b1;
        end

        id_ready_i    = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;

        pop_m = if_valid_o && rdy && !redir;
        if (pop_m) begin
            chk("pop_pc",    if_pc_o,    deliver_exp);
            chk("pop_instr", if_instr_o, deliver_exp ^ KEY);
            deliver_exp = deliver_exp + 32'd4;
            pops++;
        end
        if (redir) begin
            occ_m       = 0;
            issue_exp   = {tgt[31:2], 2'b00};
            deliver_exp = {tgt[31:2], 2'b00};
        end else begin
            occ_m = occ_m + int'(fire_good) - int'(pop_m);
        end
        redir_prev = redir;
    endtask

    // zero-wait memory for the wrap-around instance
    initial begin
        bit          pend2 = 1'b0;
        logic [31:0] paddr2 = '0;
        #23 rst2_n = 1'b1;
        forever begin
            @(negedge clk);
            if (valid2 && pcs2.size() < 4) begin
                pcs2.push_back(pc2);
                instrs2.push_back(instr2);
            end
            rvalid2 = pend2;
            rdata2  = paddr2 ^ KEY;
            pend2   = 1'b0;
            gnt2    = req2;
            if (req2) begin
                pend2  = 1'b1;
                paddr2 = addr2;
                if (addrs2.size() < 4) addrs2.push_back(addr2);
            end
        end
    end

    initial begin
        int p0;
        rsp_pend = 1'b0;
        pops     = 0;

        // buffer fills while decode stalls, drains in order, fetch resumes
        do_reset(1'b0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 0);
        repeat (8)  step(1'b1, 1'b0, 32'h0, 0);

        // zero-wait throughput: one instruction per two cycles
        repeat (6) step(1'b1, 1'b0, 32'h0, 0);
        p0 = pops;
        repeat (40) step(1'b1, 1'b0, 32'h0, 0);
        chk("throughput", 32'(pops - p0), 32'd20);

        // redirect while waiting on a slow response
        do_reset(1'b0);
        step(1'b1, 1'b0, 32'h0, 2);
        step(1'b1, 1'b1, 32'h0000_0103, 0);
        p0 = pops;
        repeat (12) step(1'b1, 1'b0, 32'h0, 0);
        chk("redirect_delivered", 32'(pops > p0), 32'h1);

        // redirect coinciding with rvalid and a pop of the single buffered entry
        do_reset(1'b0);
        step(1'b0, 1'b0, 32'h0, 0);
        step(1'b0, 1'b0, 32'h0, 0);
        step(1'b0, 1'b0, 32'h0, 0);
        step(1'b1, 1'b1, 32'h0000_0200, 0);
        repeat (6) step(1'b1, 1'b0, 32'h0, 0);

        // randomized traffic
        do_reset(1'b0);
        repeat (3000) step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rand_tgt(), -1);

        // reset pulse while WAIT, with the pending response arriving after release
        do_reset(1'b0);
        step(1'b1, 1'b0, 32'h0, 1);
        step(1'b1, 1'b0, 32'h0, 0);
        do_reset(1'b1);
        repeat (8) step(1'b1, 1'b0, 32'h0, 0);

        // wrap-around instance
        chk("wrap_addr_count", 32'(addrs2.size() >= 3), 32'h1);
        chk("wrap_pc_count",   32'(pcs2.size() >= 3),   32'h1);
        if (addrs2.size() >= 3) begin
            chk("wrap_addr0", addrs2[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", addrs2[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", addrs2[2], 32'h0000_0000);
        end
        if (pcs2.size() >= 3) begin
            chk("wrap_pc0",    pcs2[0],    32'hFFFF_FFF8);
            chk("wrap_pc2",    pcs2[2],    32'h0000_0000);
            chk("wrap_instr1", instrs2[1], 32'hFFFF_FFFC ^ KEY);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
